// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types, constants and the load-use hazard test for the pipeline controller.
// No ports; imported by pipe_hazard_ctrl.
package pipe_ctrl_pkg;
    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] ZERO_REG = 5'd0;
    localparam int WAIT_W = 16;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    // A load in EX whose destination is read by the ID instruction; $0 never hazards.
    function automatic logic load_use_hit(
        input logic                 memread,
        input logic [REG_IDX_W-1:0] rd,
        input logic [REG_IDX_W-1:0] rs,
        input logic [REG_IDX_W-1:0] rt,
        input logic                 uses_rt
    );
        return memread && (rd != ZERO_REG) && ((rd == rs) || (uses_rt && (rd == rt)));
    endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones.
// Ports: clk_i clock; rst_n async active-low reset to 0; inc_i count this cycle; cnt_o current value.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_n,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (inc_i && !(&r_cnt))
            r_cnt <= r_cnt + 1'b1;
    end

    assign cnt_o = r_cnt;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: sequencing controller for the 5-stage pipeline registers.
// Inputs: ID rs/rt/uses_rt, EX load/rd/branch-taken, MEM request/ready.
// Outputs: per-stage load enables, IF/ID and ID/EX flushes, MEM/WB bubble,
//          state (RUN/MEM_WAIT/ERR), sticky timeout error, saturating stall/flush counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n,
    input  logic [REG_IDX_W-1:0] id_rs_i,
    input  logic [REG_IDX_W-1:0] id_rt_i,
    input  logic                 id_uses_rt_i,
    input  logic                 ex_memread_i,
    input  logic [REG_IDX_W-1:0] ex_rd_i,
    input  logic                 ex_branch_taken_i,
    input  logic                 mem_req_i,
    input  logic                 mem_ready_i,
    output logic                 pc_en_o,
    output logic                 ifid_en_o,
    output logic                 ifid_flush_o,
    output logic                 idex_en_o,
    output logic                 idex_flush_o,
    output logic                 exmem_en_o,
    output logic                 memwb_en_o,
    output logic                 memwb_bubble_o,
    output logic [1:0]           state_o,
    output logic                 err_o,
    output logic [CNT_W-1:0]     stall_cnt_o,
    output logic [CNT_W-1:0]     flush_cnt_o
);
    state_t              r_state, w_state_nxt;
    logic [WAIT_W-1:0]   r_wait_cnt, w_wait_nxt, w_wait_inc;
    logic                r_err, w_err_nxt;
    logic                w_in_err, w_mem_wait, w_branch, w_load_use;
    logic                w_pc_en, w_ifid_en, w_ifid_flush, w_idex_en, w_idex_flush;
    logic                w_exmem_en, w_memwb_en, w_memwb_bubble;

    // Once in MEM_WAIT only readiness matters; the request was already accepted.
    assign w_in_err   = (r_state == ERR);
    assign w_mem_wait = ((r_state == RUN) && mem_req_i && !mem_ready_i) ||
                        ((r_state == MEM_WAIT) && !mem_ready_i);
    assign w_branch   = !w_in_err && !w_mem_wait && ex_branch_taken_i;
    assign w_load_use = !w_in_err && !w_mem_wait && !ex_branch_taken_i &&
                        load_use_hit(ex_memread_i, ex_rd_i, id_rs_i, id_rt_i, id_uses_rt_i);
    assign w_wait_inc = (r_state == RUN) ? WAIT_W'(1) : r_wait_cnt + 1'b1;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_err      <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        w_err_nxt   = r_err;
        if (!w_in_err) begin
            if (w_mem_wait) begin
                w_wait_nxt = w_wait_inc;
                if (w_wait_inc >= WAIT_W'(MEM_TIMEOUT)) begin
                    w_state_nxt = ERR;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_state_nxt = MEM_WAIT;
                end
            end else begin
                w_state_nxt = RUN;
                w_wait_nxt  = '0;
            end
        end
    end

    // MEM/WB keeps loading during a wait but takes a bubble, so the stalled
    // instruction's write-back happens only once, on the ready cycle.
    always_comb begin
        w_pc_en        = !(w_in_err || w_mem_wait || w_load_use);
        w_ifid_en      = w_pc_en;
        w_ifid_flush   = w_branch;
        w_idex_en      = !(w_in_err || w_mem_wait);
        w_idex_flush   = w_branch || w_load_use;
        w_exmem_en     = !(w_in_err || w_mem_wait);
        w_memwb_en     = !w_in_err;
        w_memwb_bubble = w_mem_wait;
    end

    assign pc_en_o        = rst_n && w_pc_en;
    assign ifid_en_o      = rst_n && w_ifid_en;
    assign ifid_flush_o   = rst_n && w_ifid_flush;
    assign idex_en_o      = rst_n && w_idex_en;
    assign idex_flush_o   = rst_n && w_idex_flush;
    assign exmem_en_o     = rst_n && w_exmem_en;
    assign memwb_en_o     = rst_n && w_memwb_en;
    assign memwb_bubble_o = rst_n && w_memwb_bubble;
    assign state_o        = r_state;
    assign err_o          = r_err;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .inc_i (!w_pc_en),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .inc_i (w_branch),
        .cnt_o (flush_cnt_o)
    );
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench for pipe_hazard_ctrl with directed and random stimulus.
module tb_pipe_hazard_ctrl;
    localparam int TO    = 4;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk_i = 1'b0;
    logic          rst_n = 1'b0;
    logic [4:0]    id_rs_i = '0, id_rt_i = '0, ex_rd_i = '0;
    logic          id_uses_rt_i = 1'b0, ex_memread_i = 1'b0, ex_branch_taken_i = 1'b0;
    logic          mem_req_i = 1'b0, mem_ready_i = 1'b0;
    logic          pc_en_o, ifid_en_o, ifid_flush_o, idex_en_o, idex_flush_o;
    logic          exmem_en_o, memwb_en_o, memwb_bubble_o, err_o;
    logic [1:0]    state_o;
    logic [CW-1:0] stall_cnt_o, flush_cnt_o;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_uses_rt_i(id_uses_rt_i),
        .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i), .ex_branch_taken_i(ex_branch_taken_i),
        .mem_req_i(mem_req_i), .mem_ready_i(mem_ready_i),
        .pc_en_o(pc_en_o), .ifid_en_o(ifid_en_o), .ifid_flush_o(ifid_flush_o),
        .idex_en_o(idex_en_o), .idex_flush_o(idex_flush_o), .exmem_en_o(exmem_en_o),
        .memwb_en_o(memwb_en_o), .memwb_bubble_o(memwb_bubble_o),
        .state_o(state_o), .err_o(err_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [7:0] ctl;
        logic [1:0] st;
        logic       err;
        logic [3:0] stall;
        logic [3:0] flush;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0, failures = 0, cyc = 0;
    int   m_state = 0, m_wait = 0, m_stall = 0, m_flush = 0;
    bit   m_err = 0;

    function automatic int sat(input int v);
        return (v + 1 > CMAX) ? CMAX : v + 1;
    endfunction

    // Reference: classify the cycle, read controls from a per-event table,
    // then advance the abstract pipeline status for the next edge.
    task automatic step(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                        input logic ur, input logic mr, input logic [4:0] rd,
                        input logic br, input logic rq, input logic rdy);
        exp_t e;
        string ev;
        @(negedge clk_i);
        rst_n = rst; id_rs_i = rs; id_rt_i = rt; id_uses_rt_i = ur;
        ex_memread_i = mr; ex_rd_i = rd; ex_branch_taken_i = br;
        mem_req_i = rq; mem_ready_i = rdy;
        if (!rst) ev = "rst";
        else if (m_state == 2) ev = "err";
        else if ((m_state == 0 && rq && !rdy) || (m_state == 1 && !rdy)) ev = "wait";
        else if (br) ev = "br";
        else if (mr && rd != 0 && (rd == rs || (ur && rd == rt))) ev = "lu";
        else ev = "run";
        if (ev == "rst") begin
            m_state = 0; m_wait = 0; m_stall = 0; m_flush = 0; m_err = 0;
        end
        // ctl = {pc, ifid, ifid_flush, idex, idex_flush, exmem, memwb, bubble}
        case (ev)
            "rst", "err": e.ctl = 8'b0000_0000;
            "wait":       e.ctl = 8'b0000_0011;
            "br":         e.ctl = 8'b1111_1110;
            "lu":         e.ctl = 8'b0001_1110;
            default:      e.ctl = 8'b1101_0110;
        endcase
        e.st = 2'(m_state); e.err = m_err; e.stall = 4'(m_stall); e.flush = 4'(m_flush);
        exp_q.push_back(e);
        case (ev)
            "err": m_stall = sat(m_stall);
            "wait": begin
                m_wait  = (m_state == 0) ? 1 : m_wait + 1;
                m_stall = sat(m_stall);
                if (m_wait >= TO) begin m_state = 2; m_err = 1; end
                else m_state = 1;
            end
            "br": begin m_flush = sat(m_flush); m_state = 0; m_wait = 0; end
            "lu": begin m_stall = sat(m_stall); m_state = 0; m_wait = 0; end
            "run": begin m_state = 0; m_wait = 0; end
            default: ;
        endcase
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_i);
            #2;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("controls", {pc_en_o, ifid_en_o, ifid_flush_o, idex_en_o, idex_flush_o,
                                 exmem_en_o, memwb_en_o, memwb_bubble_o}, e.ctl);
                chk("state", state_o, e.st);
                chk("err", err_o, e.err);
                chk("stall_cnt", stall_cnt_o, e.stall);
                chk("flush_cnt", flush_cnt_o, e.flush);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench timeout");
    end

    initial begin : driver
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        // load-use on rs, then $0 destination
        step(1, 8, 0, 0, 1, 8, 0, 0, 0);
        step(1, 8, 0, 0, 0, 8, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0, 0, 0, 0);
        // rt gating
        step(1, 1, 9, 0, 1, 9, 0, 0, 0);
        step(1, 1, 9, 1, 1, 9, 0, 0, 0);
        step(1, 1, 9, 1, 0, 9, 0, 0, 0);
        // branch overrides load-use
        step(1, 8, 0, 0, 1, 8, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        // memory wait of three cycles, ready on the fourth with a load-use pending
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step(1, 8, 0, 0, 1, 8, 0, 1, 0);
        step(1, 8, 0, 0, 1, 8, 0, 1, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        // timeout into ERR, late ready ignored, reset recovers
        repeat (4) step(1, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (3) step(1, 0, 0, 0, 0, 0, 1, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        // reset asserted mid-MEM_WAIT, sampled before any clock edge
        repeat (2) step(1, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        // saturation of both counters
        repeat (20) step(1, 3, 0, 0, 1, 3, 0, 0, 0);
        repeat (20) step(1, 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // random traffic with small register indices so hazards are common
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 49) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) < 2),
                 ($urandom_range(0, 4) < 3));
        end
        repeat (3) @(negedge clk_i);
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain leftover=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Sequencing controller for the 5-stage pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Detects load-use hazards, flushes on taken branches, and freezes the pipe while the data memory is not ready.
- Inserts a bubble into MEM/WB during a memory wait so write-back is never duplicated.
- Keeps saturating performance counters and a sticky memory-timeout error.

Parameters:
MEM_TIMEOUT, 255, max consecutive cycles in MEM_WAIT before entering ERR (range 1..65535)
CNT_W, 16, width of the stall and flush performance counters

Ports:
clk_i  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
id_rs_i  in  5  rs field of the instruction in ID
id_rt_i  in  5  rt field of the instruction in ID
id_uses_rt_i  in  1  ID instruction reads rt
ex_memread_i  in  1  instruction in EX is a load
ex_rd_i  in  5  destination register of the instruction in EX
ex_branch_taken_i  in  1  branch resolved taken in EX
mem_req_i  in  1  instruction in MEM accesses data memory
mem_ready_i  in  1  data memory completes the access this cycle
pc_en_o  out  1  PC load enable
ifid_en_o  out  1  IF/ID load enable
ifid_flush_o  out  1  IF/ID loads zero (NOP)
idex_en_o  out  1  ID/EX load enable
idex_flush_o  out  1  ID/EX loads zero (bubble)
exmem_en_o  out  1  EX/MEM load enable
memwb_en_o  out  1  MEM/WB load enable
memwb_bubble_o  out  1  MEM/WB loads zero (decoder bits cleared)
state_o  out  2  current state: RUN=0, MEM_WAIT=1, ERR=2
err_o  out  1  sticky memory-timeout error
stall_cnt_o  out  CNT_W  cycles with pc_en_o=0, saturating
flush_cnt_o  out  CNT_W  taken-branch flushes, saturating

Behaviour:
- Reset (rst_n=0, asynchronous): state=RUN, wait counter=0, err_o=0, both perf counters=0.
- While rst_n=0, all *_en_o, *_flush_o and memwb_bubble_o are forced to 0, combinationally.
- Enable, flush and bubble outputs are combinational from the registered state and the current inputs. Counters, state and err_o are registered.
- Default in RUN with no event: all enables 1; all flush and bubble outputs 0.
- Priority within a cycle: ERR > memory wait > branch flush > load-use.
- Memory wait:
  - Condition: in RUN with mem_req_i=1 and mem_ready_i=0.
  - Outputs: pc/ifid/idex/exmem enables = 0; memwb_en_o=1 with memwb_bubble_o=1.
  - Next state: MEM_WAIT; wait counter := 1.
- MEM_WAIT:
  - mem_ready_i=0: same outputs as the memory-wait entry cycle; wait counter increments.
  - Counter reaching MEM_TIMEOUT with mem_ready_i still 0: next state ERR, err_o := 1.
  - mem_ready_i=1: RUN-cycle outputs apply that same cycle (full advance, including any branch/load-use evaluation); next state RUN; counter := 0.
- Branch flush (ex_branch_taken_i=1, no memory wait):
  - ifid_flush_o=1 and idex_flush_o=1; all enables 1.
  - flush_cnt_o increments next edge.
  - Any load-use stall is suppressed, because the ID instruction is discarded.
- Load-use hazard:
  - Condition: ex_memread_i=1, ex_rd_i != 0, and (ex_rd_i == id_rs_i or (id_uses_rt_i and ex_rd_i == id_rt_i)).
  - Outputs: pc_en_o=0, ifid_en_o=0, idex_flush_o=1; exmem and memwb enables 1.
  - Lasts exactly one cycle because the load advances to MEM.
- ERR: all enables 0 and all flushes 0 until reset; mem_ready_i is ignored.
- stall_cnt_o increments on each cycle (rst_n high) with pc_en_o=0, including ERR.
- Both counters saturate at all-ones with no wrap.
- Register $0 as a destination never causes a stall.

Decomposition:
- Package pipe_ctrl_pkg:
  - state enum: RUN, MEM_WAIT, ERR
  - REG_IDX_W=5
  - ZERO_REG=5'd0
- Sub-module sat_counter (width parameter, inc input, async reset), instantiated twice for the perf counters.
- Wait counter and state machine stay inline.

Test Plan:
1. Load-use hazard: ex_memread_i=1, ex_rd_i=8, id_rs_i=8 for 1 cycle -> pc_en_o=0, ifid_en_o=0, idex_flush_o=1 that cycle; stall_cnt_o=1 afterwards. Repeat with ex_rd_i=0 -> no stall.
2. rt gating: ex_rd_i=9, id_rt_i=9 -> with id_uses_rt_i=0, no stall; with id_uses_rt_i=1, one-cycle stall.
3. Branch overrides load-use: ex_branch_taken_i=1 together with a load-use hit -> ifid_flush_o=idex_flush_o=1, pc_en_o=1, flush_cnt_o=1, stall_cnt_o unchanged.
4. Memory wait: mem_req_i=1, mem_ready_i=0 for 3 cycles, then 1 -> state_o=1 for 3 cycles with memwb_bubble_o=1 and front enables 0; full advance on the ready cycle; state_o=0 next; stall_cnt_o=3.
5. Timeout: MEM_TIMEOUT=4, mem_ready_i held 0 -> state_o=2 and err_o=1 after 4 wait cycles; late mem_ready_i=1 ignored; rst_n pulse clears to RUN with counters 0.
6. Asynchronous reset mid-MEM_WAIT and counter saturation: rst_n low between edges -> enables 0 immediately, state_o=0. With CNT_W=4, 20 stall cycles -> stall_cnt_o=15.
